if_prefetch_ctrl: RTL and testbench
===================================

Name: if_prefetch_ctrl

Overview:
- Synchronous instruction-fetch request generator with a small prefetch FIFO.
- Issues word addresses to instruction memory using a req/gnt/rvalid protocol.
- Tracks outstanding transactions, buffers returned words, and presents them to the fetch-capture stage with a valid/ready handshake.
- Handles branch redirects by flushing buffered words and discarding in-flight responses.

Parameters:
- BOOT_ADDR, 32'h0000_0080, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, >= 2).
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests (<= FIFO_DEPTH).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- branch_i  in  1  redirect fetch this cycle.
- branch_addr_i  in  32  redirect target; bits [1:0] ignored (forced 0).
- instr_req_o  out  1  memory request.
- instr_addr_o  out  32  memory word address, [1:0] always 0.
- instr_gnt_i  in  1  request accepted this cycle.
- instr_rvalid_i  in  1  response data valid this cycle.
- instr_rdata_i  in  32  response instruction word.
- instr_err_i  in  1  response bus error.
- fetch_valid_o  out  1  FIFO head valid.
- fetch_rdata_o  out  32  FIFO head instruction.
- fetch_addr_o  out  32  FIFO head address.
- fetch_err_o  out  1  FIFO head error flag.
- fetch_ready_i  in  1  consumer pops head when high with fetch_valid_o.

Behaviour:
- Reset (rst_i=1 at edge): the following all clear to 0: instr_req_o, fetch_valid_o, fetch_rdata_o, fetch_addr_o, fetch_err_o, FIFO count, outstanding count (outs) and discard count (disc). instr_addr_o is set to BOOT_ADDR and the state to BOOT. Reset overrides all other inputs, including mid-transaction; responses arriving after reset are not counted.
- FSM state BOOT: one cycle with no request, then go to RUN.
- FSM state RUN: normal prefetch.
- FSM state DISCARD: entered when a redirect leaves responses in flight.
- Request condition (registered): instr_req_o=1 in RUN/DISCARD when outs + fifo_count + pending_req < FIFO_DEPTH and outs < MAX_OUTSTANDING. Once asserted, instr_req_o and instr_addr_o hold stable until gnt, except on branch.
- On gnt: outs+1, instr_addr_o += 4 (32-bit wrap 0xFFFF_FFFC -> 0x0000_0000), and req stays asserted next cycle only if the condition still holds.
- On rvalid: outs-1.
  - If disc>0: disc-1 and the data is dropped.
  - Otherwise the data is written at the FIFO tail with its address, taken from an internal response-address counter that advances by 4 per accepted response.
- Simultaneous gnt and rvalid in one cycle: outs is unchanged.
- Pop: fetch_valid_o && fetch_ready_i removes the head; the next entry is visible on the following cycle (no combinational bypass, write-to-valid latency 1 cycle).
- Simultaneous push and pop when full is legal; space reservation prevents overflow. An rvalid that would overflow is an assertion failure.
- Branch (branch_i=1 at edge, RUN or DISCARD):
  - FIFO is cleared and fetch_valid_o=0 next cycle.
  - instr_addr_o and the response-address counter are set to {branch_addr_i[31:2],2'b00}.
  - disc is set to outs after this cycle's gnt/rvalid are accounted (a gnt in the branch cycle counts as an old request and is discarded).
  - instr_req_o is deasserted for that edge and re-evaluated in the next cycle.
  - State becomes DISCARD if disc>0, otherwise RUN.
- Branch in the BOOT cycle: the target replaces BOOT_ADDR.
- Branch while a pop happens: the branch wins and the pop is ignored.
- DISCARD -> RUN when disc reaches 0. New requests may issue in DISCARD, since the outs limit covers both old and new requests.
- Error: the error bit is stored per entry. After an erroneous entry is popped, prefetching continues unchanged; the consumer decides what to do.

Optional Feature:
- Macro IF_PREFETCH_ERR_EN.
- Defined: instr_err_i is captured per FIFO entry and presented on fetch_err_o.
- Undefined: no error storage, instr_err_i is ignored, and fetch_err_o is tied 0.

Decomposition:
- Shared package if_pkg holds:
  - typedef prefetch_state_e {BOOT, RUN, DISCARD};
  - typedef fetch_entry_t {rdata[31:0], addr[31:0], err};
  - constant INSTR_BYTES=4.
- One sub-module, if_prefetch_fifo: parameterised-depth synchronous FIFO of fetch_entry_t with clear, push, pop, count, full and empty.

Test Plan:
- Reset then gnt=1 and rvalid one cycle after each gnt: addresses 0x80, 0x84, 0x88 issue in order; first fetch_valid_o with addr 0x80 appears 1 cycle after its rvalid.
- fetch_ready_i=0 with continuous gnt/rvalid: at most 2 words are buffered, instr_req_o drops, outs=0, and no overflow occurs.
- Two requests outstanding, branch_i with target 0x1002: both old responses are dropped, the next request address is 0x1000, and the first delivered fetch_addr_o is 0x1000.
- Branch in the same cycle as rvalid and a pop: the FIFO ends empty and that rvalid's data never appears.
- Address wrap: branch to 0xFFFF_FFFC gives delivered addresses 0xFFFF_FFFC then 0x0000_0000.
- With IF_PREFETCH_ERR_EN, instr_err_i=1 on the second response: fetch_err_o=1 only for the entry at addr 0x84. Without the macro, fetch_err_o stays 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types for the instruction prefetch controller: FSM states and FIFO entry layout.
package if_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DISCARD
  } prefetch_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Power-of-two depth synchronous FIFO of fetch entries with clear, push, pop and occupancy.
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  output fetch_entry_t             data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t          mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_ok);
    end
  end

  // Storage carries no reset; visibility is governed by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/if_prefetch_ctrl.sv
// Instruction fetch request generator with prefetch buffer and branch flush.
// Optional macro IF_PREFETCH_ERR_EN stores instr_err_i per entry and drives fetch_err_o.
module if_prefetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        fetch_err_o,
  input  logic        fetch_ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  prefetch_state_e state_q, state_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d, raddr_q, raddr_d;
  logic [CW-1:0]   outs_q, outs_d, disc_q, disc_d;
  logic [CW-1:0]   outs_nxt, cnt_nxt, fifo_cnt;
  logic            gnt_acc, rvalid_acc, drop, push, pop, space_ok;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    wr_entry, head;

  assign gnt_acc    = req_q && instr_gnt_i;
  assign rvalid_acc = instr_rvalid_i && (outs_q != '0);
  assign drop       = rvalid_acc && (disc_q != '0);
  assign push       = rvalid_acc && !drop && !branch_i;
  assign pop        = !fifo_empty && fetch_ready_i && !branch_i;
  assign outs_nxt   = outs_q + CW'(gnt_acc) - CW'(rvalid_acc);
  assign cnt_nxt    = fifo_cnt + CW'(push) - CW'(pop);
  // A new request reserves a buffer slot, so words in flight plus buffered never exceed the depth.
  assign space_ok   = (({1'b0, outs_nxt} + {1'b0, cnt_nxt}) < (CW+1)'(FIFO_DEPTH)) &&
                      (outs_nxt < CW'(MAX_OUTSTANDING));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    raddr_d = raddr_q;
    outs_d  = outs_nxt;
    disc_d  = disc_q;
    if (gnt_acc) addr_d  = addr_q + 32'(INSTR_BYTES);
    if (drop)    disc_d  = disc_q - CW'(1);
    if (push)    raddr_d = raddr_q + 32'(INSTR_BYTES);
    if (branch_i) begin
      addr_d  = {branch_addr_i[31:2], 2'b00};
      raddr_d = {branch_addr_i[31:2], 2'b00};
      disc_d  = outs_nxt;
      req_d   = 1'b0;
      state_d = (outs_nxt != '0) ? DISCARD : RUN;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_d = RUN;
          req_d   = space_ok;
        end
        RUN, DISCARD: begin
          req_d = (req_q && !gnt_acc) ? 1'b1 : space_ok;
          if (state_q == DISCARD && disc_d == '0) state_d = RUN;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      req_q   <= 1'b0;
      addr_q  <= {BOOT_ADDR[31:2], 2'b00};
      raddr_q <= {BOOT_ADDR[31:2], 2'b00};
      outs_q  <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      raddr_q <= raddr_d;
      outs_q  <= outs_d;
      disc_q  <= disc_d;
    end
  end

  always_comb begin
    wr_entry.rdata = instr_rdata_i;
    wr_entry.addr  = raddr_q;
`ifdef IF_PREFETCH_ERR_EN
    wr_entry.err   = instr_err_i;
`else
    wr_entry.err   = 1'b0;
`endif
  end

  if_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (branch_i),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign instr_req_o   = req_q;
  assign instr_addr_o  = addr_q;
  assign fetch_valid_o = !fifo_empty;
  assign fetch_rdata_o = fifo_empty ? 32'h0 : head.rdata;
  assign fetch_addr_o  = fifo_empty ? 32'h0 : head.addr;
`ifdef IF_PREFETCH_ERR_EN
  assign fetch_err_o   = !fifo_empty && head.err;
`else
  logic unused_err;
  assign unused_err    = instr_err_i ^ head.err;
  assign fetch_err_o   = 1'b0;
`endif

  overflow_chk: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_if_prefetch_ctrl.sv
// Directed bench for if_prefetch_ctrl with a one-cycle-latency memory responder.
module tb_if_prefetch_ctrl;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;
  logic        fetch_valid_o;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_err_o;
  logic        fetch_ready_i = 1'b0;

  always #5 clk = ~clk;

  if_prefetch_ctrl #(
    .BOOT_ADDR(32'h0000_0080), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o), .fetch_addr_o(fetch_addr_o),
    .fetch_err_o(fetch_err_o), .fetch_ready_i(fetch_ready_i)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0]  gq[$];
  logic [31:0]  gl[$];
  fetch_entry_t got[$];
  logic         rsp_hold = 1'b0;
  int           err_at = -1;
  int           rsp_n = 0;

  // Memory: answers each grant one cycle later, in order, data = addr ^ A5A5_0000.
  always @(posedge clk) begin : responder
    logic [31:0] a;
    if (rst_i) begin
      gq.delete(); gl.delete(); rsp_n = 0;
    end else if (instr_req_o && instr_gnt_i) begin
      gq.push_back(instr_addr_o); gl.push_back(instr_addr_o);
    end
    #1;
    if (!rst_i && !rsp_hold && gq.size() > 0) begin
      a = gq.pop_front();
      instr_rvalid_i = 1'b1; instr_rdata_i = a ^ 32'hA5A5_0000; instr_err_i = (rsp_n == err_at);
      rsp_n++;
    end else begin
      instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    end
  end

  always @(posedge clk) begin : consumer
    if (rst_i) got.delete();
    else if (fetch_valid_o && fetch_ready_i && !branch_i)
      got.push_back('{rdata: fetch_rdata_o, addr: fetch_addr_o, err: fetch_err_o});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_addr(input int i);
    return (i < got.size()) ? got[i].addr : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] got_data(input int i);
    return (i < got.size()) ? got[i].rdata : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] got_err(input int i);
    return (i < got.size()) ? 32'(got[i].err) : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] gl_at(input int i);
    return (i < gl.size()) ? gl[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1; branch_i = 1'b0; branch_addr_i = '0;
    instr_gnt_i = 1'b0; fetch_ready_i = 1'b0;
    cyc(2);
    rst_i = 1'b0;
    chk({tag, "_req"},   32'(instr_req_o),   32'h0);
    chk({tag, "_addr"},  instr_addr_o,       32'h0000_0080);
    chk({tag, "_valid"}, 32'(fetch_valid_o), 32'h0);
    chk({tag, "_rdata"}, fetch_rdata_o,      32'h0);
    chk({tag, "_faddr"}, fetch_addr_o,       32'h0);
    chk({tag, "_ferr"},  32'(fetch_err_o),   32'h0);
  endtask

  initial begin
    int old_cnt;

    // Sequential fetch from boot address
    do_reset("rst1");
    instr_gnt_i = 1'b1; fetch_ready_i = 1'b1;
    cyc(1);
    chk("t1_req_first",  32'(instr_req_o), 32'h1);
    chk("t1_addr_first", instr_addr_o,     32'h0000_0080);
    cyc(1);
    chk("t1_addr_second", instr_addr_o,      32'h0000_0084);
    chk("t1_valid_early", 32'(fetch_valid_o), 32'h0);
    cyc(1);
    chk("t1_valid",  32'(fetch_valid_o), 32'h1);
    chk("t1_faddr",  fetch_addr_o,       32'h0000_0080);
    chk("t1_frdata", fetch_rdata_o,      32'hA5A5_0080);
    chk("t1_req_full", 32'(instr_req_o), 32'h0);
    cyc(12);
    chk("t1_gnt0", gl_at(0), 32'h0000_0080);
    chk("t1_gnt1", gl_at(1), 32'h0000_0084);
    chk("t1_gnt2", gl_at(2), 32'h0000_0088);
    chk("t1_got0", got_addr(0), 32'h0000_0080);
    chk("t1_got1", got_addr(1), 32'h0000_0084);
    chk("t1_got2", got_addr(2), 32'h0000_0088);
    chk("t1_dat2", got_data(2), 32'hA5A5_0088);

    // Back-pressure: buffer fills to depth, requests stop
    do_reset("rst2");
    instr_gnt_i = 1'b1;
    cyc(12);
    chk("t2_valid", 32'(fetch_valid_o),       32'h1);
    chk("t2_req",   32'(instr_req_o),         32'h0);
    chk("t2_head",  fetch_addr_o,             32'h0000_0080);
    chk("t2_count", 32'(dut.u_fifo.count_o),  32'h2);
    chk("t2_outs",  32'(dut.outs_q),          32'h0);
    chk("t2_ngnt",  32'(gl.size()),           32'h2);
    fetch_ready_i = 1'b1;
    cyc(15);
    chk("t2_got0", got_addr(0), 32'h0000_0080);
    chk("t2_got1", got_addr(1), 32'h0000_0084);
    chk("t2_got2", got_addr(2), 32'h0000_0088);

    // Branch with two responses in flight
    do_reset("rst3");
    instr_gnt_i = 1'b1; fetch_ready_i = 1'b1; rsp_hold = 1'b1;
    cyc(3);
    chk("t3_outs_pre", 32'(dut.outs_q), 32'h2);
    branch_i = 1'b1; branch_addr_i = 32'h0000_1002;
    cyc(1);
    branch_i = 1'b0; rsp_hold = 1'b0;
    chk("t3_req_br",  32'(instr_req_o), 32'h0);
    chk("t3_addr_br", instr_addr_o,     32'h0000_1000);
    chk("t3_state",   32'(dut.state_q), 32'(DISCARD));
    cyc(15);
    chk("t3_gnt2",  gl_at(2),    32'h0000_1000);
    chk("t3_got0",  got_addr(0), 32'h0000_1000);
    chk("t3_dat0",  got_data(0), 32'hA5A5_1000);
    chk("t3_got1",  got_addr(1), 32'h0000_1004);
    chk("t3_state_end", 32'(dut.state_q), 32'(RUN));

    // Branch coincident with rvalid and pop
    do_reset("rst4");
    instr_gnt_i = 1'b1; fetch_ready_i = 1'b1;
    cyc(3);
    chk("t4_valid_pre", 32'(fetch_valid_o), 32'h1);
    branch_i = 1'b1; branch_addr_i = 32'h0000_2000;
    cyc(1);
    branch_i = 1'b0;
    chk("t4_valid_post", 32'(fetch_valid_o), 32'h0);
    old_cnt = 0;
    cyc(15);
    foreach (got[i]) if (got[i].addr < 32'h0000_2000) old_cnt++;
    chk("t4_old_words", 32'(old_cnt),  32'h0);
    chk("t4_got0",      got_addr(0),   32'h0000_2000);
    chk("t4_got1",      got_addr(1),   32'h0000_2004);

    // Branch in boot cycle to the top of the address space
    do_reset("rst5");
    instr_gnt_i = 1'b1; fetch_ready_i = 1'b1;
    branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFFE;
    cyc(1);
    branch_i = 1'b0;
    chk("t5_addr_br", instr_addr_o, 32'hFFFF_FFFC);
    cyc(15);
    chk("t5_gnt0", gl_at(0),    32'hFFFF_FFFC);
    chk("t5_gnt1", gl_at(1),    32'h0000_0000);
    chk("t5_got0", got_addr(0), 32'hFFFF_FFFC);
    chk("t5_got1", got_addr(1), 32'h0000_0000);
    chk("t5_dat1", got_data(1), 32'hA5A5_0000);

    // Bus error on the second response
    err_at = 1;
    do_reset("rst6");
    instr_gnt_i = 1'b1; fetch_ready_i = 1'b1;
    cyc(15);
    chk("t6_got1", got_addr(1), 32'h0000_0084);
    chk("t6_err0", got_err(0),  32'h0);
`ifdef IF_PREFETCH_ERR_EN
    chk("t6_err1", got_err(1),  32'h1);
`else
    chk("t6_err1", got_err(1),  32'h0);
`endif
    chk("t6_err2", got_err(2),  32'h0);
    chk("t6_got3", got_addr(3), 32'h0000_008C);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
